// File: rtl/ft_bus_scheduler.sv
// Half-duplex FT245-style FIFO bus scheduler: arbitrates read and write cycles
// on the shared bus and generates count-timed strobes with an idle gap between cycles.
module ft_bus_scheduler #(
  parameter int unsigned RD_END_CYCLE_TIME    = 25,
  parameter int unsigned RD_SAMPLE_TIME       = 9,
  parameter int unsigned RD_STROBE_START_TIME = 2,
  parameter int unsigned RD_STROBE_STOP_TIME  = 12,
  parameter int unsigned WR_END_CYCLE_TIME    = 25,
  parameter int unsigned WR_STROBE_START_TIME = 5,
  parameter int unsigned WR_STROBE_STOP_TIME  = 15,
  parameter int unsigned WR_ZZZ_START_TIME    = 2,
  parameter int unsigned WR_ZZZ_STOP_TIME     = 22,
  parameter int unsigned GAP_TIME             = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       FT_RXFn,
  input  logic       FT_TXEn,
  input  logic [7:0] FT_DATA_In,
  output logic       FT_RDn,
  output logic       FT_WR,
  output logic [7:0] FT_DATA_Out,
  output logic       FT_DATA_OE,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       rxf_p0, rxf_p1, txe_p0, txe_p1;
  logic       rxf_req, txe_ok;
  logic       last_grant_wr;
  logic       rd_grant, wr_grant;
  logic       oe_win, wr_win;

  // Stage p0/p1: two-flop synchronizers for the asynchronous FIFO flags
  always_ff @(posedge clk) begin
    if (!clrn) begin
      rxf_p0 <= 1'b1;
      rxf_p1 <= 1'b1;
      txe_p0 <= 1'b1;
      txe_p1 <= 1'b1;
    end else begin
      rxf_p0 <= FT_RXFn;
      rxf_p1 <= rxf_p0;
      txe_p0 <= FT_TXEn;
      txe_p1 <= txe_p0;
    end
  end

  assign rxf_req = ~rxf_p1;
  assign txe_ok  = ~txe_p1;

  always_comb begin
    state_nxt = state;
    rd_grant  = 1'b0;
    wr_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (rxf_req && tx_valid && txe_ok) begin
          // Round-robin under contention: the side not served last wins
          rd_grant = last_grant_wr;
          wr_grant = ~last_grant_wr;
        end else begin
          rd_grant = rxf_req;
          wr_grant = tx_valid & txe_ok;
        end
        if (rd_grant)      state_nxt = RD;
        else if (wr_grant) state_nxt = WR;
      end
      RD:  if (cnt == 8'(RD_END_CYCLE_TIME)) state_nxt = GAP;
      WR:  if (cnt == 8'(WR_END_CYCLE_TIME)) state_nxt = GAP;
      GAP: if (cnt == 8'(GAP_TIME - 1))      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      last_grant_wr <= 1'b1;
      FT_DATA_Out   <= 8'h00;
      rx_data       <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= 8'd0;
      else if (state != IDLE) cnt <= cnt + 8'd1;
      if (rd_grant) last_grant_wr <= 1'b0;
      if (wr_grant) begin
        last_grant_wr <= 1'b1;
        FT_DATA_Out   <= tx_data;
      end
      if (state == RD && cnt == 8'(RD_SAMPLE_TIME)) rx_data <= FT_DATA_In;
    end
  end

  // Strobes decode from registered state/count; WR is gated by OE so it can never drive an undriven bus
  assign oe_win = (state == WR) && (cnt >= 8'(WR_ZZZ_START_TIME)) && (cnt < 8'(WR_ZZZ_STOP_TIME));
  assign wr_win = (state == WR) && (cnt >= 8'(WR_STROBE_START_TIME)) && (cnt < 8'(WR_STROBE_STOP_TIME));

  assign FT_DATA_OE = oe_win;
  assign FT_WR      = wr_win & oe_win;
  assign FT_RDn     = ~((state == RD) && (cnt >= 8'(RD_STROBE_START_TIME)) &&
                        (cnt < 8'(RD_STROBE_STOP_TIME)));
  assign rx_valid   = (state == RD) && (cnt == 8'(RD_SAMPLE_TIME + 1));
  assign tx_ready   = wr_grant;
  assign busy       = (state != IDLE);

endmodule

// File: doc/ft_bus_scheduler.md
FT_BUS_SCHEDULER -- requirements
Module: ft_bus_scheduler

Interface
REQ-001 Parameters (name, default, meaning): RD_END_CYCLE_TIME, 25, last count of a read cycle; RD_SAMPLE_TIME, 9, data capture count; RD_STROBE_START_TIME, 2, FT_RDn assert count; RD_STROBE_STOP_TIME, 12, FT_RDn release count.
REQ-002 Parameters: WR_END_CYCLE_TIME, 25; WR_STROBE_START_TIME, 5; WR_STROBE_STOP_TIME, 15; WR_ZZZ_START_TIME, 2, bus drive start; WR_ZZZ_STOP_TIME, 22, bus drive stop; GAP_TIME, 4, idle counts between cycles.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 clrn  in  1  synchronous, active-low reset.
REQ-005 FT_RXFn  in  1  low = FIFO holds a byte to read (asynchronous).
REQ-006 FT_TXEn  in  1  low = FIFO accepts a byte (asynchronous).
REQ-007 FT_DATA_In  in  8  data bus input.
REQ-008 FT_RDn  out  1  read strobe, active low.
REQ-009 FT_WR  out  1  write strobe, active high.
REQ-010 FT_DATA_Out  out  8  data bus output.
REQ-011 FT_DATA_OE  out  1  high = FPGA drives the bus.
REQ-012 tx_valid / tx_data  in  1 / 8  byte offered for transmission.
REQ-013 tx_ready  out  1  byte accepted this cycle when tx_valid & tx_ready.
REQ-014 rx_valid / rx_data  out  1 / 8  one-cycle pulse with received byte.
REQ-015 busy  out  1  high whenever state != IDLE.

Function
REQ-016 FT_RXFn and FT_TXEn SHALL pass a 2-flop synchronizer; rxf_req = ~synced RXFn, txe_ok = ~synced TXEn.
REQ-017 States SHALL be IDLE, RD, WR, GAP; 8-bit counter cnt cleared on every state entry, incremented each cycle in RD/WR/GAP.
REQ-018 IDLE: read eligible = rxf_req; write eligible = tx_valid & txe_ok; none -> stay IDLE.
REQ-019 One eligible -> enter its state; both eligible -> grant opposite of last_grant (round-robin); last_grant updated on each grant.
REQ-020 tx_ready SHALL be high only in the IDLE cycle that grants WR; tx_data latched into FT_DATA_Out that cycle and held until next WR grant.
REQ-021 RD: FT_RDn low for cnt in [RD_STROBE_START_TIME, RD_STROBE_STOP_TIME); rx_data latched at cnt==RD_SAMPLE_TIME; rx_valid pulses one cycle at cnt==RD_SAMPLE_TIME+1; at cnt==RD_END_CYCLE_TIME -> GAP.
REQ-022 WR: FT_DATA_OE high for cnt in [WR_ZZZ_START_TIME, WR_ZZZ_STOP_TIME); FT_WR high for cnt in [WR_STROBE_START_TIME, WR_STROBE_STOP_TIME); at cnt==WR_END_CYCLE_TIME -> GAP.
REQ-023 Strobe window SHALL lie strictly inside the OE window; FT_WR never high while FT_DATA_OE low.
REQ-024 GAP: all strobes inactive, OE low; at cnt==GAP_TIME-1 -> IDLE (covers synchronizer latency so stale flags never re-trigger).
REQ-025 Flag deassertion during an active RD/WR SHALL NOT abort the cycle; cycle always runs to END.
REQ-026 tx_valid dropping after acceptance has no effect; tx_valid without txe_ok waits indefinitely in IDLE.
REQ-027 FT_RDn and FT_WR SHALL never be active in the same cycle.

Reset
REQ-028 clrn low at any clock edge, including mid-cycle, SHALL force: state IDLE, cnt 0, FT_RDn 1, FT_WR 0, FT_DATA_OE 0, FT_DATA_Out 0x00, tx_ready 0, rx_valid 0, rx_data 0x00, busy 0, last_grant = WR (first contention grants RD), synchronizers to inactive (1).

Verification
REQ-029 FT_RXFn low, FT_DATA_In=0x55 -> FT_RDn low counts 2..11, rx_valid one cycle with rx_data=0x55, GAP, IDLE.
REQ-030 tx_valid=1, tx_data=0xA5, FT_TXEn low -> tx_ready one cycle, OE counts 2..21, FT_WR counts 5..14, FT_DATA_Out=0xA5.
REQ-031 RXFn low and tx_valid with TXEn low continuously after reset -> grants RD, WR, RD, WR alternately; no overlap of strobes.
REQ-032 FT_RXFn pulses high at RD cnt 15 -> cycle completes at cnt 25, exactly one rx_valid.
REQ-033 clrn low at WR cnt 10 -> next cycle FT_WR 0, OE 0, state IDLE; pending tx_valid re-granted after release.
REQ-034 tx_valid=1 with FT_TXEn high for 100 cycles -> tx_ready stays 0, busy 0; TXEn low -> write begins within 3 cycles.
